// File: rtl/mc_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control unit for the Mary/Shelley accumulator-stack CPU.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes through EXEC instead of skipping them.
module mc_control_unit #(
  parameter int unsigned OPCODE_W     = 5,
  parameter int unsigned ALUOP_W      = 4,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                flagbit,
  input  logic                MemReady,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [2:0]          MemSrc,
  output logic [2:0]          MemDst,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                MaryWrite,
  output logic                ShelleyWrite,
  output logic                CompWrite,
  output logic                RAWrite,
  output logic                PCWrite,
  output logic                SPWrite,
  output logic [1:0]          MarySrc,
  output logic [1:0]          ShelleySrc,
  output logic [1:0]          SPSrc,
  output logic                RASrc,
  output logic [2:0]          PCSrc,
  output logic                RegDst,
  output logic                RegData,
  output logic                SrcA,
  output logic [1:0]          SrcB,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic [2:0]          State,
  output logic                Busy,
  output logic                Fault,
  output logic                Illegal
);

  // Opcode map; ALU/compare opcodes equal their ALUOP code.
  localparam logic [4:0] OpLand = 5'd0,  OpLorr = 5'd1,  OpAadd = 5'd2,  OpAsub = 5'd3;
  localparam logic [4:0] OpCles = 5'd4,  OpCgre = 5'd5,  OpCequ = 5'd6,  OpAput = 5'd7;
  localparam logic [4:0] OpSwap = 5'd8,  OpJimm = 5'd9,  OpJacc = 5'd11, OpJcmp = 5'd12;
  localparam logic [4:0] OpJfnc = 5'd13, OpSput = 5'd14, OpSpek = 5'd15, OpSpop = 5'd16;
  localparam logic [4:0] OpLoad = 5'd19, OpStor = 5'd20, OpRpop = 5'd21, OpBkac = 5'd22;
  localparam logic [4:0] OpBkra = 5'd23;

  localparam int unsigned CntW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100,
    StFault  = 3'b111
  } stateT;

  stateT           state;
  logic [4:0]      op;
  logic            atFlag;
  logic [CntW-1:0] waitCnt;
  logic            faultQ;
`ifdef CU_ILLEGAL_TRAP_EN
  logic            trapOp;
`endif

  logic [31:0] opWide;
  logic        decIllegal;
  logic        decMem;
  logic        opStore;
  logic        timeoutHit;
  logic [2:0]  aluOp;

  always_comb begin
    opWide     = 32'(OPCODE);
    decIllegal = (|opWide[31:5]) || (opWide[4:3] == 2'b11) ||
                 (opWide[4:0] inside {5'd10, 5'd17, 5'd18});
    decMem     = opWide[4:0] inside {OpSput, OpSpek, OpSpop, OpRpop,
                                     OpLoad, OpStor, OpBkac, OpBkra};
    opStore    = op inside {OpSput, OpStor, OpBkac, OpBkra};
    // Fault on the edge that would take the wait count to the limit.
    timeoutHit = (MEM_WAIT_MAX != 0) && !MemReady &&
                 ((32'(waitCnt) + 32'd1) == MEM_WAIT_MAX);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= StFetch;
      op      <= '0;
      atFlag  <= 1'b0;
      waitCnt <= '0;
      faultQ  <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      trapOp  <= 1'b0;
`endif
    end else begin
      case (state)
        StFetch, StMem: begin
          if (MemReady) begin
            waitCnt <= '0;
            if (state == StFetch) state <= StDecode;
            else                  state <= opStore ? StFetch : StWb;
          end else if (timeoutHit) begin
            waitCnt <= '0;
            faultQ  <= 1'b1;
            state   <= StFault;
          end else if (MEM_WAIT_MAX != 0) begin
            waitCnt <= waitCnt + CntW'(1);
          end
        end
        StDecode: begin
          op     <= opWide[4:0];
          atFlag <= flagbit;
`ifdef CU_ILLEGAL_TRAP_EN
          trapOp <= decIllegal;
          if (decIllegal)  state <= StExec;
`else
          if (decIllegal)  state <= StFetch;
`endif
          else if (decMem) state <= StMem;
          else             state <= StExec;
        end
        StExec, StWb: state <= StFetch;
        StFault:      state <= StFault;
        default:      state <= StFetch;
      endcase
    end
  end

  always_comb begin
    MemRead = 1'b0;  MemWrite = 1'b0;  MemSrc = 3'b000;  MemDst = 3'b000;
    IRWrite = 1'b0;  RegWrite = 1'b0;  MaryWrite = 1'b0; ShelleyWrite = 1'b0;
    CompWrite = 1'b0; RAWrite = 1'b0;  PCWrite = 1'b0;   SPWrite = 1'b0;
    MarySrc = 2'b00; ShelleySrc = 2'b00; SPSrc = 2'b00;  RASrc = 1'b0;
    PCSrc = 3'b000;  RegDst = 1'b0;    RegData = 1'b0;   SrcA = 1'b0;
    SrcB = 2'b00;    aluOp = 3'd0;
    State = 3'b000;  Busy = 1'b0;      Fault = 1'b0;     Illegal = 1'b0;
    // Reset overrides every output, even before the first edge lands.
    if (!Reset) begin
      State = state;
      Busy  = (state != StFetch);
      Fault = faultQ;
      case (state)
        StFetch: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        StDecode: begin
`ifndef CU_ILLEGAL_TRAP_EN
          Illegal = decIllegal;
`endif
        end
        StExec: begin
`ifdef CU_ILLEGAL_TRAP_EN
          if (trapOp) begin
            Illegal = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = 3'b011;
            RAWrite = 1'b1;
            RASrc   = 1'b1;
          end else
`endif
          begin
            case (op)
              OpAput: begin
                if (atFlag) begin
                  ShelleyWrite = 1'b1;
                  ShelleySrc   = 2'b01;
                end else begin
                  MaryWrite = 1'b1;
                  MarySrc   = 2'b11;
                end
              end
              OpLand, OpLorr, OpAadd, OpAsub, OpCles, OpCgre, OpCequ: begin
                SrcB  = atFlag ? 2'b00 : 2'b01;
                aluOp = op[2:0];
                if (op inside {OpCles, OpCgre, OpCequ}) begin
                  CompWrite = 1'b1;
                end else begin
                  MaryWrite = 1'b1;
                  MarySrc   = 2'b01;
                end
              end
              OpJimm, OpJfnc: begin
                PCWrite = 1'b1;
                PCSrc   = atFlag ? 3'b001 : 3'b010;
                if (op == OpJfnc) begin
                  RAWrite = 1'b1;
                  RASrc   = 1'b1;
                end
              end
              OpJacc: begin
                PCWrite = 1'b1;
                PCSrc   = atFlag ? 3'b101 : 3'b100;
              end
              OpJcmp: begin
                PCWrite = 1'b1;
                PCSrc   = atFlag ? 3'b111 : 3'b110;
              end
              OpSwap: begin
                MaryWrite    = 1'b1;
                MarySrc      = 2'b10;
                ShelleyWrite = 1'b1;
                ShelleySrc   = 2'b10;
              end
              default: ;
            endcase
          end
        end
        StMem: begin
          MemWrite = opStore;
          MemRead  = !opStore;
          case (op)
            OpSpek:         MemDst = 3'b101;
            OpLoad, OpStor: MemDst = atFlag ? 3'b011 : 3'b001;
            default:        MemDst = 3'b100;
          endcase
          if (op == OpBkac) MemSrc = atFlag ? 3'b001 : 3'b000;
          if (op == OpBkra) MemSrc = 3'b010;
          if (MemReady && opStore) begin
            SPWrite = 1'b1;
            SPSrc   = 2'b01;
          end
        end
        StWb: begin
          if (op inside {OpSpek, OpSpop, OpLoad}) MaryWrite = 1'b1;
          if (op == OpRpop) RAWrite = 1'b1;
          if (op inside {OpSpop, OpRpop}) begin
            SPWrite = 1'b1;
            SPSrc   = 2'b10;
          end
        end
        default: ;
      endcase
    end
    ALUOP = ALUOP_W'(aluOp);
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-instruction expectation model checked every cycle,
// plus literal pins from hand-worked sequences (default build, MEM_WAIT_MAX = 15).
module tb_mc_control_unit;

  localparam int WaitMax = 15;

  localparam logic [4:0] LAND = 5'd0,  LORR = 5'd1,  AADD = 5'd2,  ASUB = 5'd3,  CLES = 5'd4;
  localparam logic [4:0] CGRE = 5'd5,  CEQU = 5'd6,  APUT = 5'd7,  SWAP = 5'd8,  JIMM = 5'd9;
  localparam logic [4:0] JACC = 5'd11, JCMP = 5'd12, JFNC = 5'd13, SPUT = 5'd14, SPEK = 5'd15;
  localparam logic [4:0] SPOP = 5'd16, LOAD = 5'd19, STOR = 5'd20, RPOP = 5'd21, BKAC = 5'd22;
  localparam logic [4:0] BKRA = 5'd23;

  typedef struct packed {
    logic [2:0] state;
    logic       busy, fault, illegal, memRead, memWrite;
    logic [2:0] memSrc, memDst;
    logic       irWrite, regWrite, maryWrite, shelleyWrite, compWrite, raWrite, pcWrite, spWrite;
    logic [1:0] marySrc, shelleySrc, spSrc;
    logic       raSrc;
    logic [2:0] pcSrc;
    logic       regDst, regData, srcA;
    logic [1:0] srcB;
    logic [3:0] aluOp;
  } outT;

  logic clk = 1'b0, reset = 1'b1, flagbit = 1'b0, memReady = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic MemRead, MemWrite, IRWrite, RegWrite, MaryWrite, ShelleyWrite, CompWrite, RAWrite;
  logic PCWrite, SPWrite, RASrc, RegDst, RegData, SrcA, Busy, Fault, Illegal;
  logic [2:0] MemSrc, MemDst, PCSrc, State;
  logic [1:0] MarySrc, ShelleySrc, SPSrc, SrcB;
  logic [3:0] ALUOP;

  outT   act, exp;
  bit    expValid = 1'b0;
  string tag = "";
  int    checks = 0, failures = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.OPCODE_W(5), .ALUOP_W(4), .MEM_WAIT_MAX(WaitMax)) dut (
    .CLK(clk), .Reset(reset), .OPCODE(opcode), .flagbit(flagbit), .MemReady(memReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSrc(MemSrc), .MemDst(MemDst),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MaryWrite(MaryWrite), .ShelleyWrite(ShelleyWrite),
    .CompWrite(CompWrite), .RAWrite(RAWrite), .PCWrite(PCWrite), .SPWrite(SPWrite),
    .MarySrc(MarySrc), .ShelleySrc(ShelleySrc), .SPSrc(SPSrc), .RASrc(RASrc), .PCSrc(PCSrc),
    .RegDst(RegDst), .RegData(RegData), .SrcA(SrcA), .SrcB(SrcB), .ALUOP(ALUOP),
    .State(State), .Busy(Busy), .Fault(Fault), .Illegal(Illegal)
  );

  always_comb begin
    act.state = State;         act.busy = Busy;             act.fault = Fault;
    act.illegal = Illegal;     act.memRead = MemRead;       act.memWrite = MemWrite;
    act.memSrc = MemSrc;       act.memDst = MemDst;         act.irWrite = IRWrite;
    act.regWrite = RegWrite;   act.maryWrite = MaryWrite;   act.shelleyWrite = ShelleyWrite;
    act.compWrite = CompWrite; act.raWrite = RAWrite;       act.pcWrite = PCWrite;
    act.spWrite = SPWrite;     act.marySrc = MarySrc;       act.shelleySrc = ShelleySrc;
    act.spSrc = SPSrc;         act.raSrc = RASrc;           act.pcSrc = PCSrc;
    act.regDst = RegDst;       act.regData = RegData;       act.srcA = SrcA;
    act.srcB = SrcB;           act.aluOp = ALUOP;
  end

  // Single compare process: every driven cycle is checked against the model.
  always @(negedge clk) begin
    if (expValid) begin
      checks = checks + 1;
      if (act !== exp) begin
        failures = failures + 1;
        $display("FAIL %s @%0t: got=%h want=%h", tag, $time, act, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic bit isIll(input logic [4:0] o);
    return (o >= 5'd24) || (o == 5'd10) || (o == 5'd17) || (o == 5'd18);
  endfunction
  function automatic bit isMemOp(input logic [4:0] o);
    return o inside {SPUT, SPEK, SPOP, RPOP, LOAD, STOR, BKAC, BKRA};
  endfunction
  function automatic bit isStore(input logic [4:0] o);
    return o inside {SPUT, STOR, BKAC, BKRA};
  endfunction

  function automatic outT fetchExp(input bit rdy);
    outT e = '0;
    e.memRead = 1'b1;
    if (rdy) begin e.irWrite = 1'b1; e.pcWrite = 1'b1; end
    return e;
  endfunction

  function automatic outT decodeExp(input logic [4:0] o);
    outT e = '0;
    e.state = 3'd1; e.busy = 1'b1; e.illegal = isIll(o);
    return e;
  endfunction

  function automatic outT faultExp();
    outT e = '0;
    e.state = 3'd7; e.busy = 1'b1; e.fault = 1'b1;
    return e;
  endfunction

  function automatic outT execExp(input logic [4:0] o, input bit f);
    outT e = '0;
    e.state = 3'd2; e.busy = 1'b1;
    case (o)
      APUT: if (f) begin e.shelleyWrite = 1; e.shelleySrc = 2'b01; end
            else   begin e.maryWrite = 1;    e.marySrc = 2'b11;    end
      LAND, LORR, AADD, ASUB: begin
        e.srcB = f ? 2'b00 : 2'b01; e.maryWrite = 1; e.marySrc = 2'b01;
        e.aluOp = (o == LAND) ? 4'd0 : (o == LORR) ? 4'd1 : (o == AADD) ? 4'd2 : 4'd3;
      end
      CLES, CGRE, CEQU: begin
        e.srcB = f ? 2'b00 : 2'b01; e.compWrite = 1;
        e.aluOp = (o == CEQU) ? 4'd6 : (o == CLES) ? 4'd4 : 4'd5;
      end
      JIMM: begin e.pcWrite = 1; e.pcSrc = f ? 3'b001 : 3'b010; end
      JACC: begin e.pcWrite = 1; e.pcSrc = f ? 3'b101 : 3'b100; end
      JCMP: begin e.pcWrite = 1; e.pcSrc = f ? 3'b111 : 3'b110; end
      JFNC: begin e.pcWrite = 1; e.pcSrc = f ? 3'b001 : 3'b010; e.raWrite = 1; e.raSrc = 1; end
      SWAP: begin
        e.maryWrite = 1; e.marySrc = 2'b10; e.shelleyWrite = 1; e.shelleySrc = 2'b10;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic outT memExp(input logic [4:0] o, input bit f, input bit rdy);
    outT e = '0;
    e.state = 3'd3; e.busy = 1'b1;
    e.memWrite = isStore(o); e.memRead = !isStore(o);
    if (o == SPEK)                   e.memDst = 3'b101;
    else if (o == LOAD || o == STOR) e.memDst = f ? 3'b011 : 3'b001;
    else                             e.memDst = 3'b100;
    if (o == BKAC) e.memSrc = f ? 3'b001 : 3'b000;
    if (o == BKRA) e.memSrc = 3'b010;
    if (rdy && isStore(o)) begin e.spWrite = 1; e.spSrc = 2'b01; end
    return e;
  endfunction

  function automatic outT wbExp(input logic [4:0] o);
    outT e = '0;
    e.state = 3'd4; e.busy = 1'b1;
    if (o == SPEK || o == SPOP || o == LOAD) e.maryWrite = 1;
    if (o == RPOP) e.raWrite = 1;
    if (o == SPOP || o == RPOP) begin e.spWrite = 1; e.spSrc = 2'b10; end
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input bit rdy, input logic [4:0] o, input bit f,
                     input outT e, input string nm);
    @(posedge clk); #1;
    reset = rst; memReady = rdy; opcode = o; flagbit = f;
    exp = e; tag = nm; expValid = 1'b1;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      failures = failures + 1;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Opcode/flag are driven with junk outside DECODE to prove they are latched there.
  task automatic runInstr(input logic [4:0] o, input bit f, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, ~o, ~f, fetchExp(1'b0), "fetchWait");
    cyc(1'b0, 1'b1, ~o, ~f, fetchExp(1'b1), "fetchAccept");
    cyc(1'b0, 1'b0, o, f, decodeExp(o), "decode");
    if (isIll(o)) return;
    if (isMemOp(o)) begin
      for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, ~o, ~f, memExp(o, f, 1'b0), "memWait");
      cyc(1'b0, 1'b1, ~o, ~f, memExp(o, f, 1'b1), "memAccept");
      if (!isStore(o)) cyc(1'b0, 1'b0, ~o, ~f, wbExp(o), "writeback");
    end else begin
      cyc(1'b0, 1'b0, ~o, ~f, execExp(o, f), "exec");
    end
  endtask

  initial begin
    cyc(1'b1, 1'b1, AADD, 1'b0, '0, "reset0");
    cyc(1'b1, 1'b1, AADD, 1'b0, '0, "reset1");

    runInstr(AADD, 1'b0, 0, 0);
    lit("aadd.ALUOP", int'(ALUOP), 2);
    lit("aadd.SrcB", int'(SrcB), 1);
    lit("aadd.MaryWrite", int'(MaryWrite), 1);
    lit("aadd.MarySrc", int'(MarySrc), 1);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, fetchExp(1'b0), "aaddBackToFetch");
    lit("aadd.fetchAgain", int'(State), 0);

    runInstr(LOAD, 1'b1, 0, 3);
    lit("load@.wbMaryWrite", int'(MaryWrite), 1);
    lit("load@.wbMarySrc", int'(MarySrc), 0);

    runInstr(SPOP, 1'b0, 0, 0);
    lit("spop.SPWrite", int'(SPWrite), 1);
    lit("spop.SPSrc", int'(SPSrc), 2);
    lit("spop.MaryWrite", int'(MaryWrite), 1);

    runInstr(5'b11000, 1'b0, 0, 0);
    lit("illegal.pulse", int'(Illegal), 1);
    lit("illegal.PCWrite", int'(PCWrite), 0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, fetchExp(1'b0), "illegalSkip");
    lit("illegal.backToFetch", int'(State), 0);
    lit("illegal.oneCycle", int'(Illegal), 0);

    // Reset during a STOR memory stall.
    cyc(1'b0, 1'b1, 5'd0, 1'b0, fetchExp(1'b1), "storFetch");
    cyc(1'b0, 1'b0, STOR, 1'b0, decodeExp(STOR), "storDecode");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, memExp(STOR, 1'b0, 1'b0), "storWait0");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, memExp(STOR, 1'b0, 1'b0), "storWait1");
    cyc(1'b1, 1'b0, 5'd0, 1'b0, '0, "storReset");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, fetchExp(1'b0), "storAfterReset");
    lit("storReset.State", int'(State), 0);
    lit("storReset.MemWrite", int'(MemWrite), 0);
    lit("storReset.SPWrite", int'(SPWrite), 0);

    for (int o = 0; o < 32; o++)
      for (int f = 0; f < 2; f++)
        runInstr(5'(o), f[0], o % 2, o % 3);

    // MemReady on the last permitted wait cycle is accepted.
    runInstr(CEQU, 1'b1, WaitMax - 1, 0);
    runInstr(SPEK, 1'b0, 0, WaitMax - 1);

    // FETCH timeout, then reset clears the fault.
    for (int i = 0; i < WaitMax; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, fetchExp(1'b0), "toWait");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, faultExp(), "fetchFault");
    lit("fault.State", int'(State), 7);
    lit("fault.Fault", int'(Fault), 1);
    lit("fault.MemRead", int'(MemRead), 0);
    cyc(1'b0, 1'b1, 5'd0, 1'b0, faultExp(), "faultSticky");
    cyc(1'b1, 1'b0, 5'd0, 1'b0, '0, "faultReset");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, fetchExp(1'b0), "faultCleared");
    lit("faultCleared.Fault", int'(Fault), 0);

    // MEM timeout on a LOAD.
    cyc(1'b0, 1'b1, 5'd0, 1'b0, fetchExp(1'b1), "memToFetch");
    cyc(1'b0, 1'b0, LOAD, 1'b0, decodeExp(LOAD), "memToDecode");
    for (int i = 0; i < WaitMax; i++)
      cyc(1'b0, 1'b0, 5'd0, 1'b0, memExp(LOAD, 1'b0, 1'b0), "memToWait");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, faultExp(), "memFault");
    cyc(1'b1, 1'b0, 5'd0, 1'b0, '0, "memFaultReset");
    runInstr(SWAP, 1'b0, 0, 0);

    expValid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Parametrised multicycle successor to the single-state control unit of the Mary/Shelley accumulator-stack processor.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, and stalls on a memory ready handshake.
- Watches memory accesses with a timeout counter, and flags illegal opcodes.
- Drives every datapath write-enable and mux select. Lives in ControlUnit/ and replaces the per-opcode combinational decoder at top level.

Parameters:
- OPCODE_W, 5, opcode input width. Bits above [4:0] must be zero, otherwise the opcode is illegal.
- ALUOP_W, 4, ALUOP output width. Values are zero-extended.
- MEM_WAIT_MAX, 15, maximum number of cycles spent waiting for MemReady before a fault. 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- OPCODE  in  OPCODE_W  opcode from the instruction register. Sampled in DECODE only.
- flagbit  in  1  "@" addressing flag. Sampled with OPCODE.
- MemReady  in  1  memory completes the current MemRead/MemWrite this cycle.
- MemRead, MemWrite  out  1  memory strobes. Held until MemReady.
- MemSrc  out  3  and  MemDst  out  3  memory data and address selects.
- IRWrite, RegWrite, MaryWrite, ShelleyWrite, CompWrite, RAWrite, PCWrite, SPWrite  out  1  each; one-cycle write enables.
- MarySrc, ShelleySrc, SPSrc  out  2 each; RASrc  out  1; PCSrc  out  3; RegDst, RegData, SrcA  out  1 each; SrcB  out  2; ALUOP  out  ALUOP_W.
- State  out  3  current state, for debug.
- Busy  out  1  high in every state except FETCH.
- Fault  out  1  sticky memory-timeout indicator.
- Illegal  out  1  one-cycle pulse in DECODE on an undefined opcode.

Behaviour:
- Reset has priority over all other activity, including mid-stall. On Reset: State=FETCH (000), all outputs 0, wait counter 0, Fault 0.
- State encoding: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, FAULT=111.
- FETCH: MemRead=1, MemDst=000 (PC).
  - When MemReady=1: IRWrite=1, PCWrite=1, PCSrc=000 (PC+1), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch {OPCODE, flagbit} internally.
  - Memory-class opcodes go to MEM: SPUT, SPEK, SPOP, RPOP, LOAD, STOR, BKAC, BKRA.
  - Illegal opcodes pulse Illegal=1 and go to FETCH. Illegal means 01010, 10001, 10010, 11000-11111, or any upper bit set.
  - All other opcodes go to EXEC.
- EXEC: assert the opcode's controls for exactly one cycle, then go to FETCH. Encodings, with "@" meaning flagbit=1:
  - APUT: MaryWrite, MarySrc=11. APUT@: ShelleyWrite, ShelleySrc=01.
  - Arithmetic and logic: SrcA=0, SrcB=01, or 00 when @. MaryWrite, MarySrc=01. ALUOP: AADD=2, ASUB=3, LORR=1, LAND=0.
  - Compares: same SrcA/SrcB rule, CompWrite. ALUOP: CEQU=6, CLES=4, CGRE=5.
  - JIMM: PCWrite, PCSrc=010, or 001 when @.
  - JACC: PCWrite, PCSrc=100, or 101 when @.
  - JCMP: PCWrite, PCSrc=110, or 111 when @.
  - JFNC: as JIMM, plus RAWrite, RASrc=1.
  - SWAP: MaryWrite, MarySrc=10, ShelleyWrite, ShelleySrc=10.
- MEM: hold the strobe and address/data selects until MemReady.
  - Strobe: MemWrite=1 for SPUT, STOR, BKAC, BKRA; MemRead=1 otherwise.
  - MemDst: 100 for SPUT/SPOP/RPOP/BKAC/BKRA, 101 for SPEK, 001 for LOAD/STOR, 011 for LOAD@/STOR@.
  - MemSrc: BKAC=000, BKAC@=001, BKRA=010.
  - When MemReady=1: store-class ops go to FETCH and pulse their SP update in that same cycle (SPWrite, SPSrc=01). Read-class ops go to WB.
- WB: one cycle, read data is valid.
  - MaryWrite, MarySrc=00 for SPEK, SPOP, LOAD.
  - RAWrite, RASrc=0 for RPOP.
  - SPWrite, SPSrc=10 for SPOP and RPOP.
  - Then go to FETCH.
- Wait counter:
  - Increments each cycle spent in FETCH or MEM with MemReady=0.
  - Clears when MemReady=1 or on a state change.
  - When it reaches MEM_WAIT_MAX (MEM_WAIT_MAX≠0): go to FAULT, Fault=1, all strobes 0.
- FAULT: exited only by Reset.
- MemReady arriving on the last permitted wait cycle is accepted; it is not a fault.
- Each write enable is high for exactly one cycle per instruction.
- Cycle counts with zero wait states: ALU/jump ops take 3 cycles, memory stores 3, memory reads 4.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- When defined, an illegal opcode in DECODE goes to EXEC with PCWrite=1, PCSrc=011 (trap vector), RAWrite=1, RASrc=1 (save return address), and Illegal=1.
- When undefined, an illegal opcode is skipped as a no-op: Illegal pulses and the unit returns to FETCH.

Test Plan:
- Reset=1 for 2 cycles, then release with MemReady=1 and OPCODE=00010, flagbit=0 -> FETCH, DECODE, EXEC sequence. In EXEC: ALUOP=0010, SrcB=01, MaryWrite=1, MarySrc=01; back in FETCH on the 4th edge.
- LOAD@ (10011, flagbit=1) with MemReady low for 3 cycles in MEM -> MemRead=1, MemDst=011 held for 4 cycles. Next cycle WB: MaryWrite=1, MarySrc=00.
- SPOP with MemReady=1 -> WB asserts SPWrite=1, SPSrc=10, MaryWrite=1 in the same cycle. Total 4 cycles.
- MemReady held 0 in FETCH with MEM_WAIT_MAX=15 -> after 15 wait cycles State=111, Fault=1, MemRead=0. Reset clears everything to 0.
- OPCODE=11000 -> Illegal pulses for 1 cycle, no write enables asserted. With CU_ILLEGAL_TRAP_EN: PCWrite=1, PCSrc=011, RAWrite=1.
- Reset asserted during a MEM stall of a STOR -> next cycle State=000, MemWrite=0, SPWrite=0.
